// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois linear-feedback sequence generator.
// Several steps can be taken per enabled clock; the intermediate steps are
// never visible on the outputs.
// It also provides a runtime seed load, a period-wrap pulse and an advance
// counter.
// Optional build macro: LFSR_ZERO_GUARD_EN. When it is defined, the all-zero
// state is never reached: a zero load, or a zero stepped value, is replaced
// by SEED.
module lfsr_gen #(
    parameter int               WIDTH         = 20,
    parameter logic [WIDTH-1:0] TAPS          = 20'h90000,
    parameter logic [WIDTH-1:0] SEED          = 20'h00001,
    parameter int               MODE          = 0,
    parameter int               SHIFT_PER_CLK = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_data,
    output logic             o_bit,
    output logic             o_valid,
    output logic             o_wrap,
    output logic [WIDTH-1:0] o_cnt
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] load_val;

    // One LFSR step. MODE 0 shifts the tap parity in at bit 0 (Fibonacci).
    // MODE 1 XORs the tap mask in when the bit leaving the top is set (Galois).
    function automatic logic [WIDTH-1:0] step_once(input logic [WIDTH-1:0] s);
        logic fb;
        logic [WIDTH-1:0] r;
        fb = ^(s & TAPS);
        if (MODE == 0) begin
            r = {s[WIDTH-2:0], fb};
        end else begin
            r = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : '0);
        end
        return r;
    endfunction

    // SHIFT_PER_CLK steps, unrolled into a single combinational cloud.
    function automatic logic [WIDTH-1:0] step_n(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        v = s;
        for (int k = 0; k < SHIFT_PER_CLK; k++) begin
            v = step_once(v);
        end
        return v;
    endfunction

    // Next state for an advancing edge, and the value a load would apply.
    always_comb begin
        stepped  = step_n(o_data);
        load_val = i_seed;
`ifdef LFSR_ZERO_GUARD_EN
        if (stepped == '0) begin
            stepped = SEED;
        end
        if (i_seed == '0) begin
            load_val = SEED;
        end
`endif
    end

    // State, start reference, advance counter and status pulses.
    // A load wins over enable.
    // The wrap test compares only the value seen at the clock boundary, so
    // passing through start inside an unrolled multi-step does not count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data  <= SEED;
            start   <= SEED;
            o_cnt   <= '0;
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
        end else if (i_load) begin
            o_data  <= load_val;
            start   <= load_val;
            o_cnt   <= '0;
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
        end else if (i_enable) begin
            o_data  <= stepped;
            o_valid <= 1'b1;
            if (stepped == start) begin
                o_cnt  <= '0;
                o_wrap <= 1'b1;
            end else begin
                o_cnt  <= o_cnt + CNT_ONE;
                o_wrap <= 1'b0;
            end
        end else begin
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
        end
    end

    assign o_bit = o_data[WIDTH-1];

endmodule
